_deserialize: RTL and testbench
===============================

Name: _deserialize

Overview:
- Serial-to-parallel collector; the opposite direction of the chained OR reduction, expanding one bit stream into a word instead of folding a word into one bit.
- Accepts one bit per accepted cycle and assembles OUTPUT_WIDTH bits into a parallel word.
- Presents each full word with a valid/ready handshake.
- Sits between bit-serial links and the word-wide gate chains of the library.

Parameters:
- OUTPUT_WIDTH, 8, bits per assembled word; legal range 2..32.
- COUNT_WIDTH, 5, width of the bit counter; must satisfy 2^COUNT_WIDTH > OUTPUT_WIDTH.

Ports:
- Clock  input  1  single clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DigitSupply  input  2  supply rail pair, routed unchanged to every shift cell.
- inputData  input  1  serial data bit.
- inputValid  input  1  inputData is valid this cycle.
- inputReady  output  1  block accepts a bit this cycle.
- outputData  output  OUTPUT_WIDTH  assembled word.
- outputValid  output  1  outputData holds a complete word.
- outputReady  input  1  consumer takes the word this cycle.

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-word):
  - state=COLLECT, bit count=0, shift register=0.
  - outputData=0, outputValid=0, inputReady=1.
  - Any partial word is discarded.
- Bit acceptance: a bit is accepted when inputValid && inputReady at a rising edge.
- State COLLECT:
  - inputReady=1, outputValid=0.
  - Accepted bit is stored at position count (LSB first); count increments.
  - When the accepted bit is bit OUTPUT_WIDTH-1: count wraps to 0 and the next state is HOLD.
  - outputValid rises in the cycle after the last bit is accepted (latency 1 cycle from last bit).
- State HOLD:
  - outputValid=1; outputData is stable and unchanged while outputValid=1 && !outputReady.
  - inputReady = outputReady (combinational pass-through; the only comb path input-to-output).
- Word taken (outputValid && outputReady):
  - With no bit accepted the same cycle: next state COLLECT, count=0.
  - If a bit is accepted the same cycle: it becomes bit 0 of the next word, count=1, next state COLLECT. This gives a zero-bubble stream: one word every OUTPUT_WIDTH cycles.
- Control inputs:
  - inputValid low: no state change; inputData is ignored.
  - outputReady is ignored in COLLECT.
- Datapath:
  - Bits not yet written in the current word hold their value from the previous word.
  - outputData is a registered copy taken on entry to HOLD, so stale bits never appear on the output.
- Count rules:
  - Count never exceeds OUTPUT_WIDTH-1.
  - No overflow is possible: input is back-pressured whenever a word is held.

Optional Feature:
- Macro: DESERIALIZE_MSB_FIRST_EN.
- Defined:
  - First accepted bit lands in outputData[OUTPUT_WIDTH-1] and the last in bit 0.
  - The shift direction reverses (shift left, insert at bit 0).
  - Handshake and timing are identical.
- Undefined: LSB-first as described under Behaviour.

Decomposition:
- Shared include file holds:
  - state encodings COLLECT=1'b0, HOLD=1'b1;
  - the default width constant;
  - the macro default (undefined).
- One natural sub-module: _shift_cell.
  - One register bit with load enable, asynchronous active-high reset, and DigitSupply passthrough.
  - Instantiated OUTPUT_WIDTH times via a generate loop as Place_shift_cell.
- Counter and state register stay in the top module.

Test Plan:
1. Reset mid-word: 3 bits accepted, then Reset pulsed asynchronously between edges → outputs return to reset values immediately; the next 8 bits form a fresh word, with no remnant of the first 3.
2. LSB-first assembly: with outputReady=1, send bits 1,0,1,1,0,0,1,0 on consecutive cycles → outputValid=1 one cycle after the 8th bit; outputData=8'h4D.
3. Back-pressure: word 8'hA5 held with outputReady=0 for 5 cycles while inputValid=1 → inputReady=0 throughout; outputData stays 8'hA5; no bit is counted.
4. Zero-bubble stream: 3 words 8'h01, 8'hFF, 8'h80 with inputValid and outputReady held high → outputValid pulses exactly once every 8 cycles; the words appear in order and every input bit is accepted.
5. Gapped input: bits of 8'h3C with inputValid low on alternate cycles → same word 8'h3C; count advances only on accepted bits.
6. DESERIALIZE_MSB_FIRST_EN defined: repeat scenario 2 → outputData=8'hB2.

Source files
------------

// File: rtl/_deserialize_pkg.sv
// Shared definitions for the serial-to-parallel collector.
// DESERIALIZE_MSB_FIRST_EN is left undefined by default, which gives LSB-first assembly.
package _deserialize_pkg;

  localparam int DEFAULT_OUTPUT_WIDTH = 8;
  localparam int DEFAULT_COUNT_WIDTH  = 5;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } stateType;

endpackage

// File: rtl/_deserialize_if.sv
// Handshake bundle for the deserializer.
// The serial side is valid/ready with one bit per transfer. The word side is valid/ready with one word per transfer.
interface _deserialize_if
  import _deserialize_pkg::*;
#(
  parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH
);

  logic                    inputData;
  logic                    inputValid;
  logic                    inputReady;
  logic [OUTPUT_WIDTH-1:0] outputData;
  logic                    outputValid;
  logic                    outputReady;

  modport master (
    output inputData,
    output inputValid,
    output outputReady,
    input  inputReady,
    input  outputData,
    input  outputValid
  );

  modport slave (
    input  inputData,
    input  inputValid,
    input  outputReady,
    output inputReady,
    output outputData,
    output outputValid
  );

endinterface

// File: rtl/_deserialize_shift_cell.sv
// One storage bit of the deserializer, with a load enable and asynchronous reset.
// The supply pair passes through unchanged.
module _shift_cell (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] DigitSupply,
  input  logic       load,
  input  logic       d,
  output logic       q,
  output logic [1:0] supplyOut
);

  assign supplyOut = DigitSupply;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/_deserialize.sv
// Serial-to-parallel collector that assembles OUTPUT_WIDTH accepted bits into a handshaked word.
// Optional macro DESERIALIZE_MSB_FIRST_EN: when defined, the first bit lands in the MSB (shift-left insertion).
module _deserialize
  import _deserialize_pkg::*;
#(
  parameter int OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [1:0]    DigitSupply,
  _deserialize_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(OUTPUT_WIDTH - 1);

  stateType                state;
  stateType                nextState;
  logic [COUNT_WIDTH-1:0]  count;
  logic [COUNT_WIDTH-1:0]  nextCount;
  logic                    readyNow;
  logic                    validNow;
  logic                    accept;
  logic                    loadWord;
  logic [OUTPUT_WIDTH-1:0] shiftQ;
  logic [OUTPUT_WIDTH-1:0] cellLoad;
  logic [OUTPUT_WIDTH-1:0] cellD;
  logic [OUTPUT_WIDTH-1:0] nextWord;
  logic [OUTPUT_WIDTH-1:0] wordReg;
  logic [1:0]              unusedSupply [OUTPUT_WIDTH];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= COLLECT;
      count <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
    end
  end

  // A word taken in HOLD frees the input in the same cycle, so a bit arriving then starts the next word.
  always_comb begin
    nextState = state;
    nextCount = count;
    readyNow  = 1'b1;
    validNow  = 1'b0;
    loadWord  = 1'b0;
    unique case (state)
      COLLECT: begin
        readyNow = 1'b1;
        validNow = 1'b0;
      end
      HOLD: begin
        readyNow = bus.outputReady;
        validNow = 1'b1;
        if (bus.outputReady) begin
          nextState = COLLECT;
          nextCount = '0;
        end
      end
      default: begin
        nextState = COLLECT;
        nextCount = '0;
      end
    endcase
    accept = bus.inputValid && readyNow;
    if (accept) begin
      if (count == LAST_INDEX) begin
        nextCount = '0;
        nextState = HOLD;
        loadWord  = 1'b1;
      end else begin
        nextCount = count + COUNT_WIDTH'(1);
        nextState = COLLECT;
      end
    end
  end

  always_comb begin
    cellLoad = '0;
    cellD    = '0;
`ifdef DESERIALIZE_MSB_FIRST_EN
    cellLoad = {OUTPUT_WIDTH{accept}};
    cellD    = {shiftQ[OUTPUT_WIDTH-2:0], bus.inputData};
`else
    for (int i = 0; i < OUTPUT_WIDTH; i++) begin
      cellLoad[i] = accept && (count == COUNT_WIDTH'(i));
    end
    cellD = {OUTPUT_WIDTH{bus.inputData}};
`endif
    nextWord = (cellLoad & cellD) | (~cellLoad & shiftQ);
  end

  for (genvar i = 0; i < OUTPUT_WIDTH; i++) begin : cellGen
    _shift_cell Place_shift_cell (
      .Clock      (Clock),
      .Reset      (Reset),
      .DigitSupply(DigitSupply),
      .load       (cellLoad[i]),
      .d          (cellD[i]),
      .q          (shiftQ[i]),
      .supplyOut  (unusedSupply[i])
    );
  end

  // The output word includes the last bit, which is written in the same edge, so stale shift bits never reach it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wordReg <= '0;
    end else if (loadWord) begin
      wordReg <= nextWord;
    end
  end

  assign bus.inputReady  = readyNow;
  assign bus.outputValid = validNow;
  assign bus.outputData  = wordReg;

endmodule

// File: tb/tb__deserialize.sv
// Self-checking bench for _deserialize: table vectors, hand-written corner sequences and a randomized model check.
// Honours DESERIALIZE_MSB_FIRST_EN so expectations follow the built bit order.
module tb__deserialize;
  import _deserialize_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [7:0] sendBits;
    logic       gapped;
    logic [7:0] expLsb;
    logic [7:0] expMsb;
  } vectorType;

  logic       Clock;
  logic       Reset;
  logic [1:0] DigitSupply;
  int         checks = 0;
  int         errors = 0;

  _deserialize_if #(.OUTPUT_WIDTH(W)) bus ();

  _deserialize #(.OUTPUT_WIDTH(W), .COUNT_WIDTH(5)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .DigitSupply(DigitSupply),
    .bus        (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic data, input logic ready);
    bus.inputValid  = valid;
    bus.inputData   = data;
    bus.outputReady = ready;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] pickOrder(input logic [7:0] lsbWord, input logic [7:0] msbWord);
`ifdef DESERIALIZE_MSB_FIRST_EN
    return msbWord;
`else
    return lsbWord;
`endif
  endfunction

  // Reference assembly: the k-th accepted bit goes to position k (or W-1-k when MSB first).
  function automatic logic [W-1:0] assemble(input logic bits[$]);
    logic [W-1:0] word = '0;
    for (int k = 0; k < W; k++) begin
`ifdef DESERIALIZE_MSB_FIRST_EN
      word[W-1-k] = bits[k];
`else
      word[k] = bits[k];
`endif
    end
    return word;
  endfunction

  task automatic sendWord(input logic [7:0] bits, input logic gapped, input logic ready, input string tag);
    for (int k = 0; k < W; k++) begin
      applyStimulus(1'b1, bits[k], ready);
      #1;
      checkOutput({tag, " inputReady"}, 32'(bus.inputReady), 32'd1);
      tick();
      if (k < W - 1) begin
        checkOutput({tag, " validEarly"}, 32'(bus.outputValid), 32'd0);
        if (gapped) begin
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), ready);
          tick();
          checkOutput({tag, " validGap"}, 32'(bus.outputValid), 32'd0);
        end
      end
    end
    applyStimulus(1'b0, 1'b0, ready);
  endtask

  initial begin
    vectorType  vectors [6];
    logic [7:0] streamLsb [3];
    logic [7:0] streamMsb [3];
    logic       modelBits [$];
    logic       modelHeld;
    logic [W-1:0] modelWord;
    logic       v, d, r, expReady;
    logic [7:0] cur;

    vectors[0] = '{8'h4D, 1'b0, 8'h4D, 8'hB2};
    vectors[1] = '{8'h3C, 1'b1, 8'h3C, 8'h3C};
    vectors[2] = '{8'hA5, 1'b0, 8'hA5, 8'hA5};
    vectors[3] = '{8'h96, 1'b1, 8'h96, 8'h69};
    vectors[4] = '{8'h01, 1'b0, 8'h01, 8'h80};
    vectors[5] = '{8'hFF, 1'b0, 8'hFF, 8'hFF};
    streamLsb  = '{8'h01, 8'hFF, 8'h80};
    streamMsb  = '{8'h80, 8'hFF, 8'h01};

    DigitSupply = 2'b10;
    Reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset outputValid", 32'(bus.outputValid), 32'd0);
    checkOutput("reset outputData", 32'(bus.outputData), 32'd0);
    checkOutput("reset inputReady", 32'(bus.inputReady), 32'd1);
    Reset = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      sendWord(vectors[t].sendBits, vectors[t].gapped, 1'b1, $sformatf("vec%0d", t));
      checkOutput($sformatf("vec%0d outputValid", t), 32'(bus.outputValid), 32'd1);
      checkOutput($sformatf("vec%0d outputData", t), 32'(bus.outputData),
                  32'(pickOrder(vectors[t].expLsb, vectors[t].expMsb)));
      tick();
      checkOutput($sformatf("vec%0d taken", t), 32'(bus.outputValid), 32'd0);
    end

    // Reset between edges in the middle of a word.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("midReset outputValid", 32'(bus.outputValid), 32'd0);
    checkOutput("midReset outputData", 32'(bus.outputData), 32'd0);
    checkOutput("midReset inputReady", 32'(bus.inputReady), 32'd1);
    #1;
    Reset = 1'b0;
    tick();
    sendWord(8'h1E, 1'b0, 1'b1, "afterReset");
    checkOutput("afterReset outputValid", 32'(bus.outputValid), 32'd1);
    checkOutput("afterReset outputData", 32'(bus.outputData), 32'(pickOrder(8'h1E, 8'h78)));
    tick();

    // Back-pressure: the held word blocks further input.
    sendWord(8'hA5, 1'b0, 1'b0, "bp");
    checkOutput("bp outputValid", 32'(bus.outputValid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      #1;
      checkOutput($sformatf("bp%0d inputReady", c), 32'(bus.inputReady), 32'd0);
      tick();
      checkOutput($sformatf("bp%0d outputValid", c), 32'(bus.outputValid), 32'd1);
      checkOutput($sformatf("bp%0d outputData", c), 32'(bus.outputData), 32'hA5);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("bp released", 32'(bus.outputValid), 32'd0);
    sendWord(8'h96, 1'b0, 1'b1, "postBp");
    checkOutput("postBp outputData", 32'(bus.outputData), 32'(pickOrder(8'h96, 8'h69)));
    tick();

    // Zero-bubble stream of three words.
    for (int j = 0; j < 3 * W; j++) begin
      cur = streamLsb[j / W];
      applyStimulus(1'b1, cur[j % W], 1'b1);
      #1;
      checkOutput($sformatf("stream%0d inputReady", j), 32'(bus.inputReady), 32'd1);
      tick();
      if (j % W == W - 1) begin
        checkOutput($sformatf("stream%0d outputValid", j), 32'(bus.outputValid), 32'd1);
        checkOutput($sformatf("stream%0d outputData", j), 32'(bus.outputData),
                    32'(pickOrder(streamLsb[j / W], streamMsb[j / W])));
      end else begin
        checkOutput($sformatf("stream%0d outputValid", j), 32'(bus.outputValid), 32'd0);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("stream drained", 32'(bus.outputValid), 32'd0);

    // Randomized traffic against a queue-based model.
    modelHeld = 1'b0;
    modelWord = '0;
    modelBits.delete();
    for (int c = 0; c < 1500; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 2) != 0);
      applyStimulus(v, d, r);
      #1;
      expReady = !modelHeld || r;
      checkOutput("rand inputReady", 32'(bus.inputReady), 32'(expReady));
      tick();
      if (modelHeld && r) modelHeld = 1'b0;
      if (v && expReady) begin
        modelBits.push_back(d);
        if (modelBits.size() == W) begin
          modelWord = assemble(modelBits);
          modelBits.delete();
          modelHeld = 1'b1;
        end
      end
      checkOutput("rand outputValid", 32'(bus.outputValid), 32'(modelHeld));
      if (modelHeld) checkOutput("rand outputData", 32'(bus.outputData), 32'(modelWord));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
